cordic_angle_prep: RTL and testbench
====================================

Name: cordic_angle_prep

Overview:
- Upstream stage of the CORDIC cosine core.
- Accepts an IEEE-754 single-precision angle in radians and reduces it modulo 2*pi, then folds it into [-pi/2, pi/2].
- Emits a 22-bit signed Q2.20 angle plus a result-negate flag, and a one-cycle start pulse that drives the core's clk_en.
- Because cos is even, the input sign is discarded.

Parameters:
- MAX_EXP, 134, largest accepted biased exponent (|x| < 256); larger finite inputs flag range_err.
- RED_STEPS, 6, restoring-reduction steps (subtract 2*pi*2^k, k = RED_STEPS-1 down to 0).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  angle_in is valid this cycle
- in_ready  out  1  block can accept a new angle
- angle_in  in  32  IEEE-754 single angle, radians
- angle_out  out  22  signed Q2.20 reduced angle, to CORDIC angle input
- cos_neg  out  1  downstream must negate cos_out
- out_valid  out  1  one-cycle pulse, drives CORDIC clk_en
- range_err  out  1  finite |x| >= 2^(MAX_EXP-126); valid with out_valid
- nan_flag  out  1  input was Inf/NaN; valid with out_valid

Behaviour:
- Clock and reset: one clock, clk. Synchronous active-high reset. On reset:
  - state=IDLE, in_ready=1, out_valid=0.
  - angle_out=0, cos_neg=0, range_err=0, nan_flag=0.
  - Reset mid-operation aborts the computation with no out_valid pulse.
- Handshake: accept on a rising edge where in_valid && in_ready. in_ready=1 only in IDLE. in_valid while busy is ignored and the word is not latched.
- FSM: IDLE -> CONVERT -> REDUCE (RED_STEPS cycles) -> MAP -> DONE -> IDLE.
  - Every state lasts one cycle except REDUCE.
  - Latency is fixed for all inputs, including error cases: out_valid is high for exactly one cycle, in DONE, 9 cycles after the accepting edge.
  - The earliest next accept is the cycle after DONE.
- CONVERT: unpack exp e and mantissa m = {e!=0, frac} into unsigned Q9.20, r (29 bits): r = m << (e-130) if e >= 130, else m >> (130-e), truncating.
  - e=0 (zero/denormal): r=0.
  - e=255: nan_flag=1, r=0.
  - MAX_EXP < e < 255: range_err=1, r=0.
- REDUCE: for k = 5..0, if r >= TWO_PI<<k then r -= TWO_PI<<k. Result is r in [0, 2*pi).
- Constants, Q*.20 rounded:
  - HALF_PI = 1647099
  - PI = 3294199
  - THREE_HALF_PI = 4941298
  - TWO_PI = 6588397
- MAP:
  - r <= HALF_PI: a = r, cos_neg=0.
  - HALF_PI < r <= THREE_HALF_PI: a = PI - r, cos_neg=1.
  - r > THREE_HALF_PI: a = r - TWO_PI, cos_neg=0.
  - a is computed signed and truncated to 22 bits, so |a| <= HALF_PI always fits in Q2.20.
  - On nan_flag/range_err: a=0, cos_neg=0.
- Outputs: angle_out, cos_neg, range_err and nan_flag are registered. They hold their values from DONE until the next DONE.
- Flags: both flags clear when a new angle is accepted.
- Boundaries:
  - r == HALF_PI exactly maps to branch 1.
  - r == THREE_HALF_PI exactly maps to branch 2.
  - -0.0 behaves as 0.0.

Test Plan:
- 0x00000000 (0.0) -> out_valid 9 cycles after accept; angle_out=0, cos_neg=0, flags 0.
- 0xBF800000 (-1.0) -> angle_out=0x100000, cos_neg=0.
- 0x40490FDB (pi) -> r=3294198; angle_out=22'd1, cos_neg=1.
- 0x40800000 (4.0) -> angle_out=0x3243F7 (-900105), cos_neg=1. 0x40E00000 (7.0) -> angle_out=751635, cos_neg=0.
- 0x43960000 (300.0) -> range_err=1, angle_out=0. 0x7FC00000 -> nan_flag=1. Both with the same 9-cycle latency.
- Back-to-back in_valid held high -> in_ready low for 9 cycles, second word accepted after DONE. Reset asserted in REDUCE -> no out_valid, in_ready=1 next cycle.

Source files
------------

// File: rtl/cordic_angle_prep_if.sv
// Handshake and result bundle between the angle-prep stage and its producer/consumer.
// The master side drives angles in; the slave side is the prep block itself.
interface cordic_angle_prep_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] angle_in;
    logic [21:0] angle_out;
    logic        cos_neg;
    logic        out_valid;
    logic        range_err;
    logic        nan_flag;

    modport master (
        output in_valid, angle_in,
        input  in_ready, angle_out, cos_neg, out_valid, range_err, nan_flag
    );

    modport slave (
        input  in_valid, angle_in,
        output in_ready, angle_out, cos_neg, out_valid, range_err, nan_flag
    );
endinterface

// File: rtl/cordic_angle_prep.sv
// Reduces an IEEE-754 single angle modulo 2*pi and folds it into [-pi/2, pi/2]
// as a Q2.20 value plus a cos-negate flag for the CORDIC cosine core.
module cordic_angle_prep #(
    parameter int MAX_EXP   = 134,
    parameter int RED_STEPS = 6
) (
    input  logic               clk,
    input  logic               reset,
    cordic_angle_prep_if.slave bus
);
    localparam logic [28:0] HALF_PI       = 29'd1647099;
    localparam logic [28:0] THREE_HALF_PI = 29'd4941298;
    localparam logic [28:0] TWO_PI        = 29'd6588397;
    localparam logic [21:0] PI_A          = 22'd3294199;
    localparam logic [21:0] TWO_PI_A      = 22'(6588397);
    localparam logic [7:0]  MAX_EXP_B     = 8'(MAX_EXP);
    localparam logic [2:0]  STEP_LAST     = 3'(RED_STEPS - 1);

    typedef enum logic [2:0] {IDLE, CONVERT, REDUCE, MAP, DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  step_q, step_d;
    logic [30:0] word_q, word_d;
    logic [28:0] r_q, r_d;
    logic        nan_q, nan_d;
    logic        rerr_q, rerr_d;
    logic [21:0] angle_q, angle_d;
    logic        cos_neg_q, cos_neg_d;
    logic        range_err_q, range_err_d;
    logic        nan_flag_q, nan_flag_d;

    logic [7:0]  exp_w;
    logic [28:0] mant_w;
    logic [28:0] sub_w;
    logic [21:0] a_w;
    logic        neg_w;

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        word_d      = word_q;
        r_d         = r_q;
        nan_d       = nan_q;
        rerr_d      = rerr_q;
        angle_d     = angle_q;
        cos_neg_d   = cos_neg_q;
        range_err_d = range_err_q;
        nan_flag_d  = nan_flag_q;
        exp_w       = word_q[30:23];
        mant_w      = {5'b0, (word_q[30:23] != 8'd0), word_q[22:0]};
        sub_w       = TWO_PI << step_q;
        a_w         = '0;
        neg_w       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    // Sign bit dropped here: cos is even.
                    word_d      = bus.angle_in[30:0];
                    range_err_d = 1'b0;
                    nan_flag_d  = 1'b0;
                    state_d     = CONVERT;
                end
            end
            CONVERT: begin
                nan_d  = 1'b0;
                rerr_d = 1'b0;
                if (exp_w == 8'd255) begin
                    nan_d = 1'b1;
                    r_d   = '0;
                end else if (exp_w > MAX_EXP_B) begin
                    rerr_d = 1'b1;
                    r_d    = '0;
                end else if (exp_w == 8'd0) begin
                    r_d = '0;
                end else if (exp_w >= 8'd130) begin
                    r_d = mant_w << (exp_w - 8'd130);
                end else begin
                    r_d = mant_w >> (8'd130 - exp_w);
                end
                step_d  = STEP_LAST;
                state_d = REDUCE;
            end
            REDUCE: begin
                if (r_q >= sub_w) begin
                    r_d = r_q - sub_w;
                end
                if (step_q == 3'd0) begin
                    state_d = MAP;
                end else begin
                    step_d = step_q - 3'd1;
                end
            end
            MAP: begin
                // r < 2*pi < 2^23, so modular 22-bit arithmetic gives the exact folded angle.
                if (r_q <= HALF_PI) begin
                    a_w = r_q[21:0];
                end else if (r_q <= THREE_HALF_PI) begin
                    a_w   = PI_A - r_q[21:0];
                    neg_w = 1'b1;
                end else begin
                    a_w = r_q[21:0] - TWO_PI_A;
                end
                if (nan_q || rerr_q) begin
                    a_w   = '0;
                    neg_w = 1'b0;
                end
                angle_d     = a_w;
                cos_neg_d   = neg_w;
                range_err_d = rerr_q;
                nan_flag_d  = nan_q;
                state_d     = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            step_q      <= '0;
            word_q      <= '0;
            r_q         <= '0;
            nan_q       <= 1'b0;
            rerr_q      <= 1'b0;
            angle_q     <= '0;
            cos_neg_q   <= 1'b0;
            range_err_q <= 1'b0;
            nan_flag_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            word_q      <= word_d;
            r_q         <= r_d;
            nan_q       <= nan_d;
            rerr_q      <= rerr_d;
            angle_q     <= angle_d;
            cos_neg_q   <= cos_neg_d;
            range_err_q <= range_err_d;
            nan_flag_q  <= nan_flag_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.angle_out = angle_q;
    assign bus.cos_neg   = cos_neg_q;
    assign bus.range_err = range_err_q;
    assign bus.nan_flag  = nan_flag_q;
endmodule

// File: tb/tb_cordic_angle_prep.sv
// Self-checking bench: directed and random angles against a real-arithmetic model.
module tb_cordic_angle_prep;
    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   txn      = 0;

    cordic_angle_prep_if bus ();

    cordic_angle_prep #(.MAX_EXP(134), .RED_STEPS(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Angle value times 2^20, floored, reduced with %, then folded.
    function automatic void model(input logic [31:0] w, output logic [21:0] a,
                                  output logic neg, output logic rerr, output logic nan);
        int     e;
        longint m;
        longint r;
        longint ai;
        real    v;
        e    = int'(w[30:23]);
        m    = longint'({1'b0, w[22:0]}) + ((e != 0) ? 64'sd8388608 : 64'sd0);
        nan  = 1'b0;
        rerr = 1'b0;
        neg  = 1'b0;
        r    = 0;
        if (e == 255) nan = 1'b1;
        else if (e > 134) rerr = 1'b1;
        else if (e != 0) begin
            v = real'(m) * (2.0 ** real'(e - 130));
            r = longint'($floor(v));
        end
        r = r % 6588397;
        if (r <= 1647099) ai = r;
        else if (r <= 4941298) begin
            ai  = 3294199 - r;
            neg = 1'b1;
        end else ai = r - 6588397;
        if (nan || rerr) begin
            ai  = 0;
            neg = 1'b0;
        end
        a = 22'(ai);
    endfunction

    task automatic drive_and_check(input logic [31:0] w, input logic hold_next,
                                   input logic [31:0] w_next, output logic [21:0] ea);
        logic en, er, enan;
        int   lat, nvalid, nbusy;
        model(w, ea, en, er, enan);
        bus.in_valid = 1'b1;
        bus.angle_in = w;
        check("ready_pre", bus.in_ready, 1);
        @(negedge clk);
        if (hold_next) bus.angle_in = w_next;
        else bus.in_valid = 1'b0;
        lat = 0; nvalid = 0; nbusy = 0;
        check("flags_clr", {bus.range_err, bus.nan_flag}, 0);
        for (int k = 1; k <= 9; k++) begin
            if (bus.out_valid) begin
                nvalid++;
                if (lat == 0) lat = k;
            end
            if (!bus.in_ready) nbusy++;
            if (k < 9) @(negedge clk);
        end
        check("latency", lat, 9);
        check("pulses", nvalid, 1);
        check("busy", nbusy, 9);
        check("angle_out", bus.angle_out, ea);
        check("cos_neg", bus.cos_neg, en);
        check("range_err", bus.range_err, er);
        check("nan_flag", bus.nan_flag, enan);
        $display("txn %0d in=%08h angle_out=%06h exp=%06h cos_neg=%0b rerr=%0b nan=%0b",
                 txn, w, bus.angle_out, ea, bus.cos_neg, bus.range_err, bus.nan_flag);
        txn++;
    endtask

    task automatic single(input logic [31:0] w);
        logic [21:0] ea;
        drive_and_check(w, 1'b0, 32'h0, ea);
        @(negedge clk);
        check("pulse_end", bus.out_valid, 0);
        check("hold", bus.angle_out, ea);
    endtask

    logic [31:0] directed [12] = '{
        32'h00000000, 32'hBF800000, 32'h40490FDB, 32'h40800000,
        32'h40E00000, 32'h43960000, 32'h7FC00000, 32'h80000000,
        32'h3FC90FD8, 32'h4096CBE4, 32'h437F0000, 32'h43800000
    };

    initial begin
        logic [21:0] ea;
        logic [31:0] w, f;
        int          s, e, nv;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.angle_in = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_ready", bus.in_ready, 1);
        check("rst_valid", bus.out_valid, 0);
        check("rst_angle", bus.angle_out, 0);
        check("rst_flags", {bus.cos_neg, bus.range_err, bus.nan_flag}, 0);

        foreach (directed[i]) single(directed[i]);
        single(32'h7F800000);
        single(32'h00000001);

        for (int i = 0; i < 40; i++) begin
            s = $urandom_range(0, 1);
            e = $urandom_range(100, 136);
            f = $urandom;
            if ($urandom_range(0, 2) == 0) w = $urandom;
            else w = {s[0], e[7:0], f[22:0]};
            single(w);
        end

        // In_valid held high through a busy period: second word waits for DONE.
        drive_and_check(32'h40E00000, 1'b1, 32'h40800000, ea);
        @(negedge clk);
        drive_and_check(32'h40800000, 1'b0, 32'h0, ea);
        @(negedge clk);

        // Reset in REDUCE aborts without a pulse.
        bus.in_valid = 1'b1;
        bus.angle_in = 32'h40E00000;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_ready", bus.in_ready, 1);
        check("abort_angle", bus.angle_out, 0);
        check("abort_cneg", bus.cos_neg, 0);
        nv = 0;
        for (int k = 0; k < 12; k++) begin
            if (bus.out_valid) nv++;
            @(negedge clk);
        end
        check("abort_pulse", nv, 0);
        $display("txn %0d reset-abort out_valid_pulses=%0d", txn, nv);

        single(32'h3F800000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
